// File: rtl/bus_transfer_sequencer.sv
// Bus transfer sequencer: queues (src,dst) register moves and emits registered
// drive/latch strobes for the shared register bus, two cycles per transfer.
module bus_transfer_sequencer #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [IDX_W-1:0]    req_src,
  input  logic [IDX_W-1:0]    req_dst,
  output logic [NUM_REGS-1:0] enable_out,
  output logic [NUM_REGS-1:0] enable_in,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [IDX_W-1:0] src;
    logic [IDX_W-1:0] dst;
  } req_t;

  typedef enum logic [1:0] {IDLE, DRIVE, LATCH} state_t;

  req_t                mem [DEPTH];
  logic [PW-1:0]       wp, rp;
  logic [PW:0]         count;
  logic                full, empty, push, pop, head_ok;
  req_t                head, cur;
  state_t              state, state_d;
  logic [1:0]          latch_pipe;
  logic [NUM_REGS-1:0] eo_d, ei_d;

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign head      = mem[rp];
  assign head_ok   = ({1'b0, head.src} < (IDX_W+1)'(NUM_REGS)) &&
                     ({1'b0, head.dst} < (IDX_W+1)'(NUM_REGS)) &&
                     (head.src != head.dst);
  assign busy      = (state != IDLE) || !empty;
  assign done      = latch_pipe[1];

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {req_src, req_dst};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (pop && head_ok) cur <= head;
  end

  // IDLE holds off one cycle while a done is still in flight so that an
  // err pulse can never land on top of it.
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !latch_pipe[0]) begin
          pop     = 1'b1;
          state_d = head_ok ? DRIVE : IDLE;
        end
      end
      DRIVE: state_d = LATCH;
      LATCH: begin
        state_d = IDLE;
        if (!empty) begin
          pop = 1'b1;
          if (head_ok) state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    eo_d = '0;
    ei_d = '0;
    if (state == DRIVE || state == LATCH) eo_d = NUM_REGS'(1) << cur.src;
    if (state == LATCH)                   ei_d = NUM_REGS'(1) << cur.dst;
  end

  // Strobes lag the state by one cycle so they are stable for full cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_out <= '0;
      enable_in  <= '0;
      latch_pipe <= '0;
      err        <= 1'b0;
    end else begin
      enable_out <= eo_d;
      enable_in  <= ei_d;
      latch_pipe <= {latch_pipe[0], state == LATCH};
      err        <= pop && !head_ok;
    end
  end
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Self-checking bench: exact-timing vector table, directed corner sequences and
// a randomized run scored against an in-order request queue model.
module tb_bus_transfer_sequencer;
  localparam int NR = 8;

  logic          clk, reset, req_valid, req_ready, busy, done, err;
  logic [3:0]    req_src, req_dst;
  logic [NR-1:0] enable_out, enable_in;

  bus_transfer_sequencer #(.NUM_REGS(NR), .IDX_W(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .enable_out(enable_out),
    .enable_in(enable_in), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [3:0] src;
    logic [3:0] dst;
    bit         bad;
  } vec_t;

  int    checks = 0, failures = 0, cyc = 0, done_cnt = 0, err_cnt = 0;
  bit    saw_full;
  vec_t  exp_q[$];
  int    done_cyc[$];
  vec_t  mon_e;
  logic [31:0] bank [NR];
  logic [31:0] bus_v;
  bit    bank_seed = 0;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Word-register bank model: latches the bus mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (bank_seed) bank[2] = 32'hDEADBEEF;
    bus_v = 'x;
    for (int j = 0; j < NR; j++) if (enable_out[j]) bus_v = bank[j];
    for (int j = 0; j < NR; j++) if (enable_in[j]) bank[j] = bus_v;
  end

  // Scoreboard: every strobe pair or err pulse consumes the oldest accepted request.
  always @(negedge clk) begin
    chk("strobe_invariant",
        ($countones(enable_out) <= 1) && ($countones(enable_in) <= 1) &&
        ((enable_in == 0) || (enable_out != 0)) && ((enable_out & enable_in) == 0), 1);
    chk("done_err_exclusive", done && err, 0);
    if (enable_in != 0) begin
      if (exp_q.size() == 0) chk("unexpected_transfer", 0, 1);
      else begin
        mon_e = exp_q.pop_front();
        chk("xfer_not_bad", mon_e.bad, 0);
        chk("xfer_src", enable_out, 8'd1 << mon_e.src);
        chk("xfer_dst", enable_in, 8'd1 << mon_e.dst);
      end
    end
    if (err) begin
      err_cnt++;
      if (exp_q.size() == 0) chk("unexpected_err", 0, 1);
      else begin
        mon_e = exp_q.pop_front();
        chk("err_on_bad", mon_e.bad, 1);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
  end

  // Caller is at #1 after a posedge; returns at #1 after the accepting edge, valid still high.
  task automatic push_req(input logic [3:0] s, input logic [3:0] d);
    bit rdy;
    int tries = 0;
    vec_t e;
    req_valid = 1; req_src = s; req_dst = d;
    forever begin
      rdy = req_ready;
      if (!rdy) saw_full = 1;
      @(posedge clk);
      if (rdy) break;
      tries++;
      if (tries > 40) begin chk("push_timeout", 0, 1); break; end
      #1;
    end
    #1;
    if (rdy) begin
      e.src = s; e.dst = d; e.bad = (s >= NR) || (d >= NR) || (s == d);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [NR-1:0] eo_x, ei_x;
    @(posedge clk); #1;
    chk("vec_ready", req_ready, 1);
    push_req(v.src, v.dst);
    req_valid = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      eo_x = (!v.bad && (c == 2 || c == 3)) ? (8'd1 << v.src) : 8'd0;
      ei_x = (!v.bad && c == 3) ? (8'd1 << v.dst) : 8'd0;
      chk("vec_enable_out", enable_out, eo_x);
      chk("vec_enable_in", enable_in, ei_x);
      chk("vec_done", done, !v.bad && c == 4);
      chk("vec_err", err, v.bad && c == 1);
    end
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin @(negedge clk); n++; end
    chk(nm, n < 300, 1);
    repeat (4) @(negedge clk);
  endtask

  vec_t vecs[7];
  int d0, e0, okn, badn;

  initial begin
    vecs[0] = '{4'd2, 4'd5, 1'b0};
    vecs[1] = '{4'd3, 4'd3, 1'b1};
    vecs[2] = '{4'd9, 4'd1, 1'b1};
    vecs[3] = '{4'd1, 4'd0, 1'b0};
    vecs[4] = '{4'd7, 4'd0, 1'b0};
    vecs[5] = '{4'd0, 4'd7, 1'b0};
    vecs[6] = '{4'd5, 4'd12, 1'b1};

    reset = 1; req_valid = 0; req_src = 0; req_dst = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    repeat (10) begin
      @(negedge clk);
      chk("idle_enables", {enable_out, enable_in}, 0);
      chk("idle_ready", req_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_pulses", {done, err}, 0);
    end

    // Single move r2->r5 through the bank model.
    bank_seed = 1;
    @(negedge clk);
    bank_seed = 0;
    run_vec(vecs[0]);
    chk("bank_r5", bank[5], 32'hDEADBEEF);

    for (int i = 1; i < 7; i++) run_vec(vecs[i]);

    // Queued invalids followed by a valid move.
    d0 = done_cnt; e0 = err_cnt;
    @(posedge clk); #1;
    push_req(4'd3, 4'd3); push_req(4'd9, 4'd1); push_req(4'd1, 4'd0);
    req_valid = 0;
    wait_drain("invalid_drain");
    chk("invalid_errs", err_cnt - e0, 2);
    chk("invalid_dones", done_cnt - d0, 1);

    // Fill past DEPTH; drained dones must be 2 cycles apart.
    saw_full = 0; d0 = done_cnt; done_cyc.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) push_req(4'(i % 8), 4'((i + 3) % 8));
    req_valid = 0;
    chk("fill_saw_full", saw_full, 1);
    wait_drain("fill_drain");
    chk("fill_dones", done_cnt - d0, 9);
    for (int i = 1; i < 9 && i < done_cyc.size(); i++)
      chk("fill_done_gap", done_cyc[i] - done_cyc[i-1], 2);

    // Reset during the latch cycle with two requests still queued.
    @(posedge clk); #1;
    push_req(4'd1, 4'd2); push_req(4'd3, 4'd4); push_req(4'd5, 4'd6);
    req_valid = 0;
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (enable_in == 0 && n < 20);
      chk("reset_latch_seen", n < 20, 1);
    end
    reset = 1;
    d0 = done_cnt; e0 = err_cnt;
    @(posedge clk); #1;
    exp_q.delete();
    chk("rst_enables", {enable_out, enable_in}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    @(posedge clk); #1 reset = 0;
    repeat (6) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_no_err", err_cnt - e0, 0);
    begin
      vec_t v;
      v.src = 4'd4; v.dst = 4'd6; v.bad = 0;
      run_vec(v);
    end

    // Randomized traffic against the queue model.
    d0 = done_cnt; e0 = err_cnt; okn = 0; badn = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        logic [3:0] s, d;
        s = 4'($urandom_range(0, 9));
        d = 4'($urandom_range(0, 9));
        if (s >= NR || d >= NR || s == d) badn++; else okn++;
        push_req(s, d);
      end else begin
        req_valid = 0;
        @(posedge clk); #1;
      end
    end
    req_valid = 0;
    wait_drain("rand_drain");
    chk("rand_queue_empty", exp_q.size(), 0);
    chk("rand_dones", done_cnt - d0, okn);
    chk("rand_errs", err_cnt - e0, badn);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
